// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause/adjust FSM, 1 Hz and 2 Hz time bases,
// and a blink mask for the field being adjusted. Outputs feed a 4-digit display driver.
module stopwatch_ctrl #(
    parameter int CNT_1HZ   = 100000000,
    parameter int CNT_2HZ   = 50000000,
    parameter int CNT_BLINK = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       clr_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] seconds1,
    output logic [3:0] seconds2,
    output logic [3:0] minutes1,
    output logic [3:0] minutes2,
    output logic [3:0] blank,
    output logic       running,
    output logic [1:0] state_dbg
);

    localparam int W1 = (CNT_1HZ > 1) ? $clog2(CNT_1HZ) : 1;
    localparam int W2 = (CNT_2HZ > 1) ? $clog2(CNT_2HZ) : 1;
    localparam int WB = (CNT_BLINK > 1) ? $clog2(CNT_BLINK) : 1;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W1-1:0]   cnt1;
    logic [W2-1:0]   cnt2;
    logic [WB-1:0]   cntb;
    logic            phase;
    logic            phase_nxt;
    logic            enter_adj;
    logic            tick;
    logic            step;
    logic [8:0]      secs_inc;
    logic [8:0]      mins_inc;

    // Increment a two-digit BCD 00..59 field; bit 8 flags the 59 -> 00 wrap.
    function automatic logic [8:0] inc60(input logic [7:0] f);
        logic [8:0] r;
        if (f[3:0] == 4'd9) begin
            if (f[7:4] == 4'd5) r = {1'b1, 8'h00};
            else                r = {1'b0, f[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, f[7:4], f[3:0] + 4'd1};
        end
        return r;
    endfunction

    // adj dominates everything; leaving ADJUST always parks in PAUSED.
    always_comb begin
        state_nxt = state;
        if (adj)                  state_nxt = ADJUST;
        else if (state == ADJUST) state_nxt = PAUSED;
        else if (pause_btn)       state_nxt = (state == RUN) ? PAUSED : RUN;
    end

    assign enter_adj = adj && (state != ADJUST);
    assign tick      = (state == RUN) && !adj && (cnt1 == W1'(CNT_1HZ - 1));
    assign step      = (state == ADJUST) && (cnt2 == W2'(CNT_2HZ - 1));
    assign phase_nxt = (cntb == WB'(CNT_BLINK - 1)) ? ~phase : phase;
    assign secs_inc  = inc60({seconds2, seconds1});
    assign mins_inc  = inc60({minutes2, minutes1});
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= PAUSED;
            running  <= 1'b0;
            blank    <= 4'b0000;
            cnt1     <= '0;
            cnt2     <= '0;
            cntb     <= '0;
            phase    <= 1'b0;
            seconds1 <= 4'd0;
            seconds2 <= 4'd0;
            minutes1 <= 4'd0;
            minutes2 <= 4'd0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
            phase   <= phase_nxt;
            cntb    <= (cntb == WB'(CNT_BLINK - 1)) ? '0 : cntb + 1'b1;
            blank   <= (state_nxt == ADJUST && phase_nxt) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;

            // The 1 Hz fraction survives a pause; only clear/adjust-entry drop it.
            if (clr_btn || enter_adj) cnt1 <= '0;
            else if (state == RUN)    cnt1 <= tick ? '0 : cnt1 + 1'b1;

            if (clr_btn || enter_adj)   cnt2 <= '0;
            else if (state == ADJUST)   cnt2 <= step ? '0 : cnt2 + 1'b1;

            if (clr_btn) begin
                seconds1 <= 4'd0;
                seconds2 <= 4'd0;
                minutes1 <= 4'd0;
                minutes2 <= 4'd0;
            end else if (tick) begin
                {seconds2, seconds1} <= secs_inc[7:0];
                if (secs_inc[8]) {minutes2, minutes1} <= mins_inc[7:0];
            end else if (step) begin
                if (sel) {seconds2, seconds1} <= secs_inc[7:0];
                else     {minutes2, minutes1} <= mins_inc[7:0];
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with short divider periods: a vector table for the
// run/pause/clear timing, then hand sequences for adjust, blink, wrap and reset.
module tb_stopwatch_ctrl;

    localparam int C1 = 10;
    localparam int C2 = 5;
    localparam int CB = 3;
    localparam logic [1:0] ST_P = 2'd0;
    localparam logic [1:0] ST_R = 2'd1;
    localparam logic [1:0] ST_A = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause_btn;
    logic       clr_btn;
    logic       adj;
    logic       sel;
    logic [3:0] seconds1;
    logic [3:0] seconds2;
    logic [3:0] minutes1;
    logic [3:0] minutes2;
    logic [3:0] blank;
    logic       running;
    logic [1:0] state_dbg;

    logic [22:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;

    typedef struct {
        logic        pause;
        logic        clr;
        int          n;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CNT_1HZ(C1), .CNT_2HZ(C2), .CNT_BLINK(CB)) dut (
        .clk(clk), .rst(rst), .pause_btn(pause_btn), .clr_btn(clr_btn),
        .adj(adj), .sel(sel), .seconds1(seconds1), .seconds2(seconds2),
        .minutes1(minutes1), .minutes2(minutes2), .blank(blank),
        .running(running), .state_dbg(state_dbg)
    );

    function automatic logic [22:0] mk(input logic [1:0] st, input logic [15:0] t,
                                       input logic [3:0] b, input logic r);
        return {st, t, b, r};
    endfunction

    // Free-running blink phase: toggles every CB edges counted from reset release.
    function automatic logic [3:0] blink_exp(input logic s);
        if (((k / CB) % 2) == 1) return s ? 4'b0011 : 4'b1100;
        return 4'b0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst) k++;
        else     k = 0;
        #1;
    endtask

    task automatic push_exp(input logic [22:0] w);
        exp_q.push_back(w);
    endtask

    task automatic pop_cmp(input string name);
        logic [22:0] obs;
        logic [22:0] e;
        obs = {state_dbg, minutes2, minutes1, seconds2, seconds1, blank, running};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                n_bad++;
                $display("FAIL %s: got st=%0d t=%h blank=%b run=%b, want st=%0d t=%h blank=%b run=%b",
                         name, obs[22:21], obs[20:5], obs[4:1], obs[0],
                         e[22:21], e[20:5], e[4:1], e[0]);
            end
        end
    endtask

    task automatic chk(input string name, input logic [22:0] w);
        push_exp(w);
        pop_cmp(name);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 49,  mk(ST_P, 16'h0000, 4'b0, 1'b0)};
        vecs[1]  = '{1'b1, 1'b0, 9,   mk(ST_R, 16'h0000, 4'b0, 1'b1)};
        vecs[2]  = '{1'b0, 1'b0, 0,   mk(ST_R, 16'h0001, 4'b0, 1'b1)};
        vecs[3]  = '{1'b0, 1'b0, 889, mk(ST_R, 16'h0130, 4'b0, 1'b1)};
        vecs[4]  = '{1'b0, 1'b0, 8,   mk(ST_R, 16'h0130, 4'b0, 1'b1)};
        vecs[5]  = '{1'b0, 1'b1, 0,   mk(ST_R, 16'h0000, 4'b0, 1'b1)};
        vecs[6]  = '{1'b0, 1'b0, 8,   mk(ST_R, 16'h0000, 4'b0, 1'b1)};
        vecs[7]  = '{1'b0, 1'b0, 0,   mk(ST_R, 16'h0001, 4'b0, 1'b1)};
        vecs[8]  = '{1'b0, 1'b0, 3,   mk(ST_R, 16'h0001, 4'b0, 1'b1)};
        vecs[9]  = '{1'b1, 1'b0, 0,   mk(ST_P, 16'h0001, 4'b0, 1'b0)};
        vecs[10] = '{1'b0, 1'b0, 99,  mk(ST_P, 16'h0001, 4'b0, 1'b0)};
        vecs[11] = '{1'b1, 1'b0, 3,   mk(ST_R, 16'h0001, 4'b0, 1'b1)};
        vecs[12] = '{1'b0, 1'b0, 0,   mk(ST_R, 16'h0001, 4'b0, 1'b1)};
        vecs[13] = '{1'b0, 1'b0, 0,   mk(ST_R, 16'h0002, 4'b0, 1'b1)};
        vecs[14] = '{1'b1, 1'b1, 0,   mk(ST_P, 16'h0000, 4'b0, 1'b0)};
        vecs[15] = '{1'b0, 1'b0, 20,  mk(ST_P, 16'h0000, 4'b0, 1'b0)};

        rst = 1'b0; pause_btn = 1'b0; clr_btn = 1'b0; adj = 1'b0; sel = 1'b0;
        repeat (3) cyc();
        chk("reset", mk(ST_P, 16'h0000, 4'b0, 1'b0));
        rst = 1'b1;

        // Run/pause/clear timing: pulse for one edge, then idle n edges.
        for (int i = 0; i < 16; i++) begin
            pause_btn = vecs[i].pause;
            clr_btn   = vecs[i].clr;
            push_exp(vecs[i].exp);
            cyc();
            pause_btn = 1'b0;
            clr_btn   = 1'b0;
            repeat (vecs[i].n) cyc();
            pop_cmp($sformatf("vec%0d", i));
        end

        // Preload 59:58 through adjust, then run across the 59:59 wrap.
        adj = 1'b1; sel = 1'b0;
        cyc();
        chk("adj_entry", mk(ST_A, 16'h0000, blink_exp(1'b0), 1'b0));
        repeat (295) cyc();
        chk("preload_min", mk(ST_A, 16'h5900, blink_exp(1'b0), 1'b0));
        sel = 1'b1;
        repeat (290) cyc();
        chk("preload_sec", mk(ST_A, 16'h5958, blink_exp(1'b1), 1'b0));
        adj = 1'b0;
        cyc();
        chk("adj_exit", mk(ST_P, 16'h5958, 4'b0, 1'b0));
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        repeat (9) cyc();
        chk("wrap_pre", mk(ST_R, 16'h5958, 4'b0, 1'b1));
        cyc();
        chk("wrap_5959", mk(ST_R, 16'h5959, 4'b0, 1'b1));
        repeat (10) cyc();
        chk("wrap_0000", mk(ST_R, 16'h0000, 4'b0, 1'b1));

        // Seconds adjust with blink, then switch to minutes mid-run.
        adj = 1'b1; sel = 1'b1;
        cyc();
        chk("adj_sec_entry", mk(ST_A, 16'h0000, blink_exp(1'b1), 1'b0));
        for (int j = 1; j <= 25; j++) begin
            cyc();
            chk($sformatf("adj_sec%0d", j), mk(ST_A, {12'h000, 4'(j / 5)}, blink_exp(1'b1), 1'b0));
        end
        sel = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            cyc();
            chk($sformatf("adj_min%0d", j), mk(ST_A, {4'h0, 4'(j / 5), 8'h05}, blink_exp(1'b0), 1'b0));
        end
        adj = 1'b0;
        cyc();
        chk("adj_leave", mk(ST_P, 16'h0205, 4'b0, 1'b0));

        // adj beats a same-cycle pause_btn, and pause_btn is ignored inside ADJUST.
        adj = 1'b1; pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        chk("adj_over_pause", mk(ST_A, 16'h0205, blink_exp(1'b0), 1'b0));
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        chk("pause_in_adj", mk(ST_A, 16'h0205, blink_exp(1'b0), 1'b0));
        adj = 1'b0;
        cyc();
        chk("adj_to_paused", mk(ST_P, 16'h0205, 4'b0, 1'b0));

        // Preload 12:34, run partway into a second, then reset.
        clr_btn = 1'b1; cyc(); clr_btn = 1'b0;
        chk("clr_paused", mk(ST_P, 16'h0000, 4'b0, 1'b0));
        adj = 1'b1; sel = 1'b0;
        cyc();
        repeat (60) cyc();
        sel = 1'b1;
        repeat (170) cyc();
        adj = 1'b0;
        cyc();
        chk("preload_1234", mk(ST_P, 16'h1234, 4'b0, 1'b0));
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        repeat (5) cyc();
        chk("run_1234", mk(ST_R, 16'h1234, 4'b0, 1'b1));
        rst = 1'b0;
        cyc();
        chk("reset_mid", mk(ST_P, 16'h0000, 4'b0, 1'b0));
        rst = 1'b1;
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        repeat (9) cyc();
        chk("post_rst_pre", mk(ST_R, 16'h0000, 4'b0, 1'b1));
        cyc();
        chk("post_rst_tick", mk(ST_R, 16'h0001, 4'b0, 1'b1));

        // Blink phase restarts from reset.
        adj = 1'b1; sel = 1'b1;
        cyc();
        chk("blink_rst_entry", mk(ST_A, 16'h0001, blink_exp(1'b1), 1'b0));
        for (int j = 1; j <= 6; j++) begin
            cyc();
            chk($sformatf("blink_rst%0d", j), mk(ST_A, (j >= 5) ? 16'h0002 : 16'h0001, blink_exp(1'b1), 1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch time-base and mode controller that generates the four BCD digits consumed by the 4-digit seven-segment display driver.
- Runs/pauses an MM:SS count from debounced button pulses.
- Provides a manual adjust mode that steps minutes or seconds at 2 Hz.
- Emits a per-digit blank mask so the display can blink the field being adjusted.

Parameters:
- CNT_1HZ, 100000000, clk cycles per 1 Hz count tick.
- CNT_2HZ, 50000000, clk cycles per adjust-mode increment.
- CNT_BLINK, 25000000, clk cycles per blink-phase toggle.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-low reset.
- pause_btn  input  1  single-cycle debounced pulse; toggles run/pause.
- clr_btn  input  1  single-cycle debounced pulse; clears time to 00:00.
- adj  input  1  level; 1 selects adjust mode.
- sel  input  1  level; adjust target: 0 = minutes, 1 = seconds.
- seconds1  output  4  seconds ones digit, BCD 0-9.
- seconds2  output  4  seconds tens digit, BCD 0-5.
- minutes1  output  4  minutes ones digit, BCD 0-9.
- minutes2  output  4  minutes tens digit, BCD 0-5.
- blank  output  4  active-high digit blank: bit0 = seconds1, bit1 = seconds2, bit2 = minutes1, bit3 = minutes2.
- running  output  1  1 while in RUN.

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-low (rst == 0), on posedge clk.
  - Reset sets all digits to 0, state = PAUSED, running = 0, blank = 4'b0000, and all divider counters and blink phase to 0.
  - All outputs are registered.
- State machine (states RUN, PAUSED, ADJUST):
  - PAUSED, pause_btn -> RUN.
  - RUN, pause_btn -> PAUSED.
  - Any state, adj == 1 -> ADJUST on the next edge. adj has priority over pause_btn; pause_btn is ignored while in or entering ADJUST.
  - ADJUST, adj == 0 -> PAUSED, never directly to RUN.
- 1 Hz divider:
  - Counts 0..CNT_1HZ-1 and advances only in RUN.
  - Holds its value in PAUSED, so the sub-second fraction is preserved across a pause.
  - Clears on entering ADJUST and on clr_btn.
  - Tick fires on the edge where the count is CNT_1HZ-1; the counter returns to 0 on that edge.
  - From the first RUN cycle with a cleared divider, the first seconds increment is visible exactly CNT_1HZ cycles later.
- Time count on tick:
  - seconds1 increments.
  - 9 -> 0 with carry into seconds2.
  - seconds2 at 5 with a carry -> 0, with carry into minutes1.
  - minutes1 9 -> 0, carry into minutes2.
  - minutes2 at 5 with a carry -> 0.
  - 59:59 wraps to 00:00; state stays RUN.
- Adjust:
  - The 2 Hz divider clears on ADJUST entry and counts 0..CNT_2HZ-1 only in ADJUST.
  - On each terminal count, the selected field (sel) increments as a 00..59 BCD value and wraps 59 -> 00 with no carry into the other field.
  - A change of sel mid-adjust takes effect on the next 2 Hz increment; the divider is not cleared.
- Blink:
  - A free-running counter toggles blink_phase every CNT_BLINK cycles.
  - In ADJUST with blink_phase == 1, blank = 4'b0011 when sel = 1, or 4'b1100 when sel = 0.
  - Otherwise blank = 4'b0000.
  - Leaving ADJUST forces blank = 0 on the same edge as the state change.
- clr_btn:
  - In any state, zeroes all digits and the 1 Hz and 2 Hz dividers on the next edge; state is unchanged.
  - clr_btn wins over a same-cycle tick or adjust increment.
  - clr_btn and pause_btn in the same cycle: both act (time cleared and state toggled).
- Reset mid-operation overrides everything; no partial-count carry survives.
- Digits are never outside legal BCD ranges; illegal input combinations are not possible since all increments are internal.

Test Plan (CNT_1HZ=10, CNT_2HZ=5, CNT_BLINK=3):
- Release rst, no buttons for 50 cycles -> digits 00:00, running=0, blank=0.
- pause_btn pulse, then run 10 cycles -> seconds1=1 exactly 10 cycles after RUN entry.
- Continue RUN to 90 ticks -> 01:30.
- Preload 59:58 via adjust, then RUN for 2 ticks -> 00:00, running still 1.
- RUN 5 cycles into a tick, pause_btn, wait 100 cycles, pause_btn -> seconds1 increments 5 cycles after resume.
- Confirm clr_btn in the same cycle as a tick -> 00:00.
- adj=1, sel=1, 25 cycles -> seconds field 05, minutes unchanged.
- During the same adjust run, blank toggles between 0000 and 0011 every 3 cycles.
- Switch sel=0 -> blank toggles between 0000 and 1100, and minutes begins stepping.
- adj=0 -> PAUSED and blank=0.
- adj=1 asserted together with pause_btn from PAUSED -> ADJUST, running=0.
- Assert rst low mid-RUN at 12:34 -> next edge 00:00, PAUSED, all dividers zero.
